uart_rx_buf: RTL and testbench

UART_RX_BUF -- requirements
Module: uart_rx_buf

---
 rtl/uart_rx_buf_pkg.sv | 18 +
 rtl/uart_rx_buf_sync_fifo.sv | 57 +++++
 rtl/uart_rx_buf.sv | 135 +++++++++++++
 tb/tb_uart_rx_buf.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buf_pkg.sv
// Purpose: shared UART definitions (receiver FSM encoding, default bit timing) for RTL and bench models.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_buf_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int UART_DEFAULT_BAUD_DIV = 868;
    localparam int UART_DATA_BITS        = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_buf_sync_fifo.sv
// Purpose: first-word-fall-through FIFO with occupancy count; storage is not reset, output is forced to 0 when empty.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push is taken when not full or when a pop lands in the same cycle; pop on empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_L);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_rx_buf.sv
// Purpose: 8N1 UART receiver with 2-flop line synchronizer, sticky error flags and a FWFT receive FIFO.
// Latency: byte on rx_data/rx_valid 3 cycles after the stop-bit centre at the pad (2 sync + 1).
// Backpressure: rx_ready pops the head; a byte arriving to a full FIFO with no pop is dropped and flags overrun.
module uart_rx_buf #(
    parameter int BAUD_DIV   = uart_rx_buf_pkg::UART_DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        sys_clk,
    input  logic                        rst_n,
    input  logic                        uart_rx,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        err_clr
);

    import uart_rx_buf_pkg::*;

    localparam int CW = $clog2(BAUD_DIV);
    typedef logic [CW-1:0] cnt_t;
    // Counters run down to zero and act on the zero cycle, hence the -1
    localparam cnt_t FULL_LOAD = cnt_t'(BAUD_DIV - 1);
    localparam cnt_t HALF_LOAD = cnt_t'(BAUD_DIV / 2 - 1);

    logic                      rx_meta;
    logic                      rx_sync;
    rx_state_e                 state;
    cnt_t                      bit_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      stop_tick;
    logic                      push;
    logic                      ferr_set;
    logic                      ovr_set;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign stop_tick = (state == ST_STOP) && (bit_cnt == '0);
    assign push      = stop_tick & rx_sync;
    assign ferr_set  = stop_tick & ~rx_sync;
    // When full, rx_valid is 1, so rx_ready alone decides whether the head frees a slot
    assign ovr_set   = push & fifo_full & ~rx_ready;
    assign rx_valid  = ~fifo_empty;

    // Two-flop synchronizer for the asynchronous pad; resets to the idle-high level
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Frame FSM: half-bit start qualification, then one sample per bit time
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state   <= ST_START;
                        bit_cnt <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (!rx_sync) begin
                        state   <= ST_DATA;
                        bit_cnt <= FULL_LOAD;
                        bit_idx <= '0;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_sync, shreg[UART_DATA_BITS-1:1]};
                        bit_cnt <= FULL_LOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
                    else               state   <= rx_sync ? ST_IDLE : ST_WAIT_HIGH;
                end
                ST_WAIT_HIGH: begin
                    // Hold off through a break so it raises only one frame error
                    if (rx_sync) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set | (frame_err & ~err_clr);
            overrun   <= ovr_set  | (overrun   & ~err_clr);
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (shreg),
        .pop      (rx_ready),
        .pop_dat  (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Purpose: randomized + directed bench for uart_rx_buf with a tty-level driver and a queue scoreboard.
// Latency: expected bytes are queued when their stop bit starts; the monitor pops on every rx_valid&rx_ready.
// Backpressure: rx_ready is driven low, high, random, or as a single pulse on a chosen cycle.
module tb_uart_rx_buf;

    import uart_rx_buf_pkg::*;

    localparam int BAUD  = 16;
    localparam int DEPTH = 8;
    localparam int CNTW  = $clog2(DEPTH) + 1;
    // Pad-relative cycle of the stop-bit centre, counted from the start-bit falling edge
    localparam int STOP_CENTRE = (1 + UART_DATA_BITS) * BAUD + BAUD / 2;
    // The DUT acts 3 cycles after the centre; inputs set this many cycles in are seen on that edge
    localparam int ACT_OFS = STOP_CENTRE + 2;

    logic            sys_clk  = 1'b0;
    logic            rst_n    = 1'b0;
    logic            uart_rx  = 1'b1;
    logic            rx_ready = 1'b0;
    logic            err_clr  = 1'b0;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [CNTW-1:0] fifo_count;
    logic            frame_err;
    logic            overrun;

    // Reference model state
    logic [7:0] exp_q[$];
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;

    int n_cmp        = 0;
    int n_bad        = 0;
    int cyc          = 0;
    int pulse_at     = -1;
    int ready_mode   = 0;   // 0 low (plus optional pulse), 1 high, 2 random
    int valid_cycles = 0;

    uart_rx_buf #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // Free-running cycle index used to place single-cycle pulses
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: sole driver of rx_ready
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            case (ready_mode)
                1:       rx_ready = 1'b1;
                2:       rx_ready = 1'($urandom_range(0, 1));
                default: rx_ready = (cyc == pulse_at);
            endcase
        end
    end

    // Monitor: every transfer is checked against the head of the expected queue
    always @(negedge sys_clk) begin
        if (rst_n && rx_valid) valid_cycles++;
        if (rst_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got byte 0x%02h, required no byte (t=%0t)", rx_data, $time);
            end else begin
                check("pop_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic hold(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // tty model: one 8N1 frame. low_stop>0 holds the stop bit low for that many bit times.
    task automatic send_frame(input logic [7:0] b, input int low_stop, input bit pop_at_push, input bit clr_at_act);
        int c0;
        c0 = cyc;
        hold(1'b0, BAUD);
        for (int i = 0; i < UART_DATA_BITS; i++) hold(b[i], BAUD);
        if (clr_at_act) begin
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end
        if (low_stop != 0)                          exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back(b);
        else                                        exp_ovr = 1'b1;
        if (pop_at_push) pulse_at = c0 + ACT_OFS;
        uart_rx = (low_stop == 0);
        for (int k = 0; k < BAUD; k++) begin
            err_clr = clr_at_act && (cyc == c0 + ACT_OFS);
            @(posedge sys_clk);
            #1;
        end
        err_clr  = 1'b0;
        pulse_at = -1;
        if (low_stop > 1) hold(1'b0, (low_stop - 1) * BAUD);
        if (low_stop != 0) hold(1'b1, BAUD);
        uart_rx = 1'b1;
    endtask

    task automatic glitch(input int len);
        hold(1'b0, len);
        hold(1'b1, 3 * BAUD);
    endtask

    task automatic check_state(input string tag);
        @(negedge sys_clk);
        check({tag, "_count"},     32'(fifo_count), exp_q.size());
        check({tag, "_valid"},     32'(rx_valid),   32'(exp_q.size() != 0));
        check({tag, "_frame_err"}, 32'(frame_err),  32'(exp_ferr));
        check({tag, "_overrun"},   32'(overrun),    32'(exp_ovr));
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        ready_mode = 1;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge sys_clk);
            #1;
            t++;
        end
        check({tag, "_drain_left"}, exp_q.size(), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        ready_mode = 0;
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge sys_clk);
        #1;
        err_clr  = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        int t;
        logic [7:0] rb;

        // Reset values
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_valid",     32'(rx_valid),   0);
        check("rst_count",     32'(fifo_count), 0);
        check("rst_data",      32'(rx_data),    0);
        check("rst_frame_err", 32'(frame_err),  0);
        check("rst_overrun",   32'(overrun),    0);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        hold(1'b1, 2 * BAUD);

        // Single good byte, consumer always ready: exactly one valid cycle
        ready_mode = 1;
        v0 = valid_cycles;
        send_frame(8'h55, 0, 1'b0, 1'b0);
        hold(1'b1, 2 * BAUD);
        check("t55_valid_cycles", valid_cycles - v0, 1);
        check_state("t55");

        // Short low pulse is rejected
        glitch(4);
        check_state("glitch4");

        // Long-low stop bit, then a good byte, then clear
        send_frame(8'hA3, 3, 1'b0, 1'b0);
        check_state("ferr_a3");
        send_frame(8'h3C, 0, 1'b0, 1'b0);
        drain("t3c");
        check_state("t3c");
        clear_err();
        check_state("ferr_clr");

        // err_clr on the same edge as a new framing error leaves it set
        send_frame(8'h5A, 1, 1'b0, 1'b1);
        check_state("setwins");
        clear_err();

        // Nine bytes into an 8-deep FIFO with no consumer
        ready_mode = 0;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b0, 1'b0);
        check_state("ovr9");
        drain("ovr9");
        clear_err();
        check_state("ovr_clr");

        // Full FIFO with a pop on the push edge: accepted, no overrun
        for (int i = 0; i < 8; i++) send_frame(8'h80 + 8'(i), 0, 1'b0, 1'b0);
        send_frame(8'h99, 0, 1'b1, 1'b0);
        check_state("fullpop");
        drain("fullpop");

        // Reset in the middle of bit 4 with a byte queued and an error pending
        send_frame(8'hC6, 0, 1'b0, 1'b0);
        send_frame(8'h11, 1, 1'b0, 1'b0);
        check_state("pre_rst");
        hold(1'b0, BAUD);
        rb = 8'hA5;
        for (int i = 0; i < 4; i++) hold(rb[i], BAUD);
        hold(rb[4], BAUD / 2);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("midrst_data", 32'(rx_data), 0);
        @(posedge sys_clk);
        #1;
        check_state("midrst");
        hold(1'b1, 2 * BAUD);
        ready_mode = 1;
        send_frame(8'hF0, 0, 1'b0, 1'b0);
        drain("tf0");
        check_state("tf0");

        // Randomized traffic with a random consumer
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            t = 0;
            while (exp_q.size() > 4 && t < 2000) begin
                @(posedge sys_clk);
                #1;
                t++;
            end
            case ($urandom_range(0, 9))
                0:       glitch(int'($urandom_range(1, BAUD / 2 - 2)));
                1:       send_frame(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)), 1'b0, 1'b0);
                default: send_frame(8'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
            endcase
            hold(1'b1, int'($urandom_range(0, BAUD)));
        end
        drain("rand");
        check_state("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
